// File: rtl/lsu_pkg.sv
// Shared LSU types: access-size encodings, the initiator state enum,
// and the sub-word merge / load-extension helpers.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } lsu_state_e;

    // Number of bytes touched; 0 flags the illegal encoding.
    function automatic logic [2:0] lsu_bytes(
        input logic [1:0] size
    );
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Overlay the low store bytes onto the word read back from memory.
    function automatic logic [31:0] lsu_merge(
        input logic [1:0]  size,
        input logic [31:0] rdata,
        input logic [31:0] wdata
    );
        logic [31:0] m;
        case (size)
            SZ_BYTE: m = {rdata[31:8], wdata[7:0]};
            SZ_HALF: m = {rdata[31:16], wdata[15:0]};
            default: m = wdata;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lsu_extend_data(
        input logic [1:0]  size,
        input logic        sgn,
        input logic [31:0] data
    );
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {{24{sgn & data[7]}}, data[7:0]};
            SZ_HALF: r = {{16{sgn & data[15]}}, data[15:0]};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational load-data extension by access size and signedness.
// Ports: size/sgn select the rule, rdata is the raw word, result is extended.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    assign result = lsu_extend_data(size, sgn, rdata);

endmodule

// File: rtl/lsu_mem_initiator.sv
// LSU data-memory initiator: one load/store at a time, RMW for sub-word
// stores, stall while busy. Ports: req_* from MEM stage, resp_* back,
// mem_* to data memory. Optional macro LSU_ALIGN_CHECK_EN flags
// misaligned half/word accesses as errors.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 32,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_data_o,
    output logic              resp_err_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ready_i
);

    localparam int AW1 = ADDR_W + 1;

    lsu_state_e state_q;
    lsu_state_e state_d;

    logic              op_write_q;
    logic [1:0]        op_size_q;
    logic              op_signed_q;
    logic [31:0]       op_wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       resp_data_q;
    logic              resp_err_q;
    logic [31:0]       ext_data;

    logic [AW1-1:0]    end_addr;
    logic              size_err;
    logic              range_err;
    logic              align_err;
    logic              req_err;
    logic              word_store;
    logic              accept;

    // One extra bit so addr + bytes cannot wrap past the range check.
    assign end_addr  = {1'b0, req_addr_i}
                     + AW1'(lsu_bytes(req_size_i));
    assign size_err  = (req_size_i == 2'b11);
    assign range_err = (end_addr > AW1'(MEM_BYTES));

`ifdef LSU_ALIGN_CHECK_EN
    assign align_err =
        ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
        ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
`else
    assign align_err = 1'b0;
`endif

    assign req_err    = size_err | range_err | align_err;
    assign word_store = req_write_i && (req_size_i == SZ_WORD);
    assign accept     = (state_q == ST_IDLE) && req_valid_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        stall_o      = 1'b1;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        resp_valid_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                stall_o     = 1'b0;
                if (req_valid_i) begin
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (word_store) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                mem_read_o = 1'b1;
                if (mem_ready_i) begin
                    state_d = op_write_q ? ST_WR : ST_RESP;
                end
            end
            ST_WR: begin
                mem_write_o = 1'b1;
                if (mem_ready_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid_o = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Address/data registers only load when entering RD or WR, so
    // they keep their last value in IDLE and RESP.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_write_q  <= 1'b0;
            op_size_q   <= SZ_BYTE;
            op_signed_q <= 1'b0;
            op_wdata_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_write_q  <= req_write_i;
                op_size_q   <= req_size_i;
                op_signed_q <= req_signed_i;
                op_wdata_q  <= req_wdata_i;
                resp_data_q <= '0;
                resp_err_q  <= req_err;
                if (!req_err) begin
                    mem_addr_q <= req_addr_i;
                    if (word_store) begin
                        mem_wdata_q <= req_wdata_i;
                    end
                end
            end
            if ((state_q == ST_RD) && mem_ready_i) begin
                if (op_write_q) begin
                    mem_wdata_q <= lsu_merge(op_size_q,
                                             mem_rdata_i,
                                             op_wdata_q);
                end else begin
                    resp_data_q <= ext_data;
                end
            end
        end
    end

    lsu_extend u_extend (
        .size   (op_size_q),
        .sgn    (op_signed_q),
        .rdata  (mem_rdata_i),
        .result (ext_data)
    );

    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign resp_data_o = resp_data_q;
    assign resp_err_o  = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator: byte-array reference model,
// directed cases then randomized traffic with random memory wait states.
module tb_lsu_mem_initiator;

    localparam int MB = 32;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_signed_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic        resp_err_o;
    logic        stall_o;
    logic [31:0] mem_addr_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    lsu_mem_initiator #(.MEM_BYTES(MB), .ADDR_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_write_i  (req_write_i),
        .req_size_i   (req_size_i),
        .req_signed_i (req_signed_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .resp_err_o   (resp_err_o),
        .stall_o      (stall_o),
        .mem_addr_o   (mem_addr_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          rd;
        int          wr;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;

    logic [7:0]  mem [64];
    logic [7:0]  refm [32];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_idx = '0;
    logic [7:0]  bd_val = '0;

    logic        rand_mode = 1'b0;
    logic        ready_force = 1'b1;
    logic        rnd_rdy = 1'b1;
    logic        lat_chk = 1'b1;

    logic        pend_vld = 1'b0;
    int          pend_addr = 0;
    int          pend_n = 0;
    logic [31:0] pend_wd = '0;

    logic [5:0]  ma;
    assign ma = mem_addr_o[5:0];
    assign mem_rdata_i = {mem[ma + 6'd3], mem[ma + 6'd2],
                          mem[ma + 6'd1], mem[ma]};
    assign mem_ready_i = rand_mode ? rnd_rdy : ready_force;

    initial forever begin
        @(posedge clk_i);
        cyc <= cyc + 1;
        rnd_rdy <= 1'($urandom_range(0, 1));
    end

    // Memory model: backdoor preload, otherwise writes when the DUT writes.
    initial forever begin
        @(posedge clk_i);
        if (bd_we) begin
            mem[bd_idx] <= bd_val;
        end else if (rst_i && mem_write_o && mem_ready_i) begin
            mem[ma]        <= mem_wdata_o[7:0];
            mem[ma + 6'd1] <= mem_wdata_o[15:8];
            mem[ma + 6'd2] <= mem_wdata_o[23:16];
            mem[ma + 6'd3] <= mem_wdata_o[31:24];
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response appears.
    int   rdc = 0;
    int   wrc = 0;
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;
    initial forever begin
        exp_t e;
        @(negedge clk_i);
        if (!rst_i) begin
            q.delete();
            rdc = 0;
            wrc = 0;
            prev_rd = 1'b0;
            prev_wr = 1'b0;
        end else begin
            if (mem_read_o || mem_write_o)
                check("rw_excl", {31'b0, mem_read_o & mem_write_o}, 0);
            if (mem_read_o && !prev_rd) rdc++;
            if (mem_write_o && !prev_wr) wrc++;
            prev_rd = mem_read_o;
            prev_wr = mem_write_o;
            if (resp_valid_o) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got resp expected none");
                end else begin
                    e = q.pop_front();
                    check("resp_err", {31'b0, resp_err_o}, {31'b0, e.err});
                    if (!e.err) check("resp_data", resp_data_o, e.data);
                    check("n_reads", rdc, e.rd);
                    check("n_writes", wrc, e.wr);
                    check("stall_ready", {30'b0, stall_o, req_ready_o}, 2);
                    if (e.lat >= 0) check("latency", cyc - e.acc + 1, e.lat);
                end
                rdc = 0;
                wrc = 0;
            end
        end
    end

    task automatic apply_pend();
        if (pend_vld) begin
            for (int i = 0; i < pend_n; i++)
                refm[pend_addr + i] = pend_wd[8*i +: 8];
            pend_vld = 1'b0;
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz,
                         input logic sg, input int ad,
                         input logic [31:0] wd);
        exp_t e;
        int n;
        int guard;
        logic [31:0] v;
        apply_pend();
        guard = 0;
        while (!req_ready_o && guard < 200) begin
            @(posedge clk_i); #1;
            guard++;
        end
        if (!req_ready_o) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout: got busy expected ready");
            return;
        end
        n = (sz == 2'd3) ? 0 : (1 << sz);
        e.err = (sz == 2'd3) || (ad + n > MB);
`ifdef LSU_ALIGN_CHECK_EN
        e.err = e.err || (sz == 2'd1 && ad % 2 != 0)
                      || (sz == 2'd2 && ad % 4 != 0);
`endif
        e.data = '0;
        e.rd = 0;
        e.wr = 0;
        if (!e.err) begin
            if (wr) begin
                e.rd = (n < 4) ? 1 : 0;
                e.wr = 1;
                pend_vld = 1'b1;
                pend_addr = ad;
                pend_n = n;
                pend_wd = wd;
            end else begin
                e.rd = 1;
                v = '0;
                for (int i = 0; i < n; i++)
                    v = v | (32'(refm[ad + i]) << (8 * i));
                if (sg && n < 4 && v[8*n-1])
                    v = v | ~((32'd1 << (8 * n)) - 32'd1);
                e.data = v;
            end
        end
        if (!lat_chk) e.lat = -1;
        else if (e.err) e.lat = 1;
        else if (wr && n < 4) e.lat = 3;
        else e.lat = 2;
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_size_i = sz;
        req_signed_i = sg;
        req_addr_i = 32'(ad);
        req_wdata_i = wd;
        e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        req_write_i = 1'($urandom_range(0, 1));
        req_size_i = 2'($urandom_range(0, 3));
        req_addr_i = $urandom;
        req_wdata_i = $urandom;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((stall_o || q.size() != 0) && guard < 500) begin
            @(posedge clk_i); #1;
            guard++;
        end
        if (stall_o || q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
    endtask

    task automatic bd_write(input int a, input logic [7:0] b);
        bd_we = 1'b1;
        bd_idx = 6'(a);
        bd_val = b;
        if (a < MB) refm[a] = b;
        @(posedge clk_i); #1;
        bd_we = 1'b0;
    endtask

    task automatic set_word(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) bd_write(a + i, w[8*i +: 8]);
    endtask

    initial begin
        int bad;
        @(negedge clk_i);
        check("rst_ready", {31'b0, req_ready_o}, 1);
        check("rst_ctl", {27'b0, stall_o, mem_read_o, mem_write_o,
                          resp_valid_o, resp_err_o}, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_rdata", resp_data_o, 0);
        for (int i = 0; i < 64; i++) bd_write(i, 8'($urandom));
        set_word(4, 32'h8899AABB);
        set_word(8, 32'h11223344);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        issue(1'b0, 2'b00, 1'b1, 4, 0);
        issue(1'b0, 2'b01, 1'b0, 4, 0);
        issue(1'b0, 2'b01, 1'b1, 4, 0);
        issue(1'b0, 2'b10, 1'b0, 4, 0);
        issue(1'b1, 2'b00, 1'b0, 8, 32'h000000EE);
        issue(1'b0, 2'b10, 1'b0, 8, 0);
        issue(1'b1, 2'b01, 1'b0, 8, 32'hFFFF5566);
        issue(1'b0, 2'b10, 1'b0, 8, 0);

        wait_idle();
        ready_force = 1'b0;
        lat_chk = 1'b0;
        issue(1'b1, 2'b10, 1'b0, 0, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("wr_hold_ctl", {29'b0, mem_write_o, stall_o,
                                  mem_read_o}, 6);
            check("wr_hold_data", mem_wdata_o, 32'hDEADBEEF);
            check("wr_hold_addr", mem_addr_o, 0);
        end
        #1 ready_force = 1'b1;
        wait_idle();
        lat_chk = 1'b1;
        issue(1'b0, 2'b10, 1'b0, 0, 0);
        issue(1'b0, 2'b10, 1'b0, 30, 0);
        issue(1'b0, 2'b11, 1'b0, 0, 0);
        issue(1'b1, 2'b01, 1'b0, 31, 32'h1234);
        issue(1'b0, 2'b00, 1'b0, 31, 0);

        wait_idle();
        apply_pend();
        ready_force = 1'b0;
        lat_chk = 1'b0;
        issue(1'b1, 2'b10, 1'b0, 12, 32'hCAFEF00D);
        @(negedge clk_i);
        check("pre_rst_wr", {31'b0, mem_write_o}, 1);
        #1 rst_i = 1'b0;
        #1;
        pend_vld = 1'b0;
        check("arst_ready", {31'b0, req_ready_o}, 1);
        check("arst_ctl", {27'b0, stall_o, mem_read_o, mem_write_o,
                           resp_valid_o, resp_err_o}, 0);
        check("arst_addr", mem_addr_o, 0);
        check("arst_wdata", mem_wdata_o, 0);
        @(posedge clk_i);
        @(posedge clk_i); #1;
        ready_force = 1'b1;
        rst_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (mem_write_o || mem_read_o) bad++;
        end
        check("post_rst_idle", bad, 0);
        lat_chk = 1'b1;
        issue(1'b0, 2'b10, 1'b0, 12, 0);

        wait_idle();
        rand_mode = 1'b1;
        lat_chk = 1'b0;
        for (int k = 0; k < 300; k++) begin
            issue(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0) ? 2'b11
                      : 2'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 35)),
                  $urandom);
        end
        wait_idle();
        apply_pend();
        bad = 0;
        for (int i = 0; i < MB; i++)
            if (mem[i] !== refm[i]) bad++;
        check("mem_final", bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
